// File: rtl/jtkcpu_regxfr.sv
// TFR/EXG register transfer engine over the D,X,Y,U,S,PC,DP,CC,A,B file with an external load port.
// Define JTKCPU_XFR_MIXW_EN to allow mixed 8/16-bit pairs; otherwise they are flagged as invalid.
module jtkcpu_regxfr #(
  parameter int unsigned     DW     = 16,
  parameter logic [DW-1:0]   RST_PC = '0,
  parameter logic [DW/2-1:0] RST_CC = 8'h50
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            cen,
  input  logic            start,
  input  logic [7:0]      op,
  input  logic [7:0]      postbyte,
  input  logic            ld_en,
  input  logic [3:0]      ld_sel,
  input  logic [DW-1:0]   ld_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [DW-1:0]   d,
  output logic [DW-1:0]   x,
  output logic [DW-1:0]   y,
  output logic [DW-1:0]   u,
  output logic [DW-1:0]   s,
  output logic [DW-1:0]   pc,
  output logic [DW/2-1:0] dp,
  output logic [DW/2-1:0] cc,
  output logic [DW/2-1:0] a,
  output logic [DW/2-1:0] b
);

  localparam int unsigned HW = DW / 2;

  typedef enum logic [2:0] {StIdle, StRead, StWrd, StWrs, StDone} state_e;

  state_e          state_q;
  logic [HW-1:0]   a_q, b_q, dp_q, cc_q;
  logic [DW-1:0]   x_q, y_q, u_q, s_q, pc_q;
  logic [DW-1:0]   tmp_s_q, tmp_d_q;
  logic [3:0]      src_q, dst_q;
  logic            exg_q, inv_q, busy_q, done_q, err_q;

  function automatic logic is_word(input logic [3:0] c);
    return c < 4'd6;
  endfunction

  function automatic logic is_byte(input logic [3:0] c);
    return c[3:2] == 2'b10;
  endfunction

  // A byte widened into a word register gets an all-ones upper half.
  function automatic logic [DW-1:0] fit(input logic [DW-1:0] v, input logic [3:0] from,
                                        input logic [3:0] to);
    if (!is_word(to)) return {{HW{1'b0}}, v[HW-1:0]};
    if (!is_word(from)) return {{HW{1'b1}}, v[HW-1:0]};
    return v;
  endfunction

  function automatic logic [DW-1:0] rd(input logic [3:0] c);
    case (c)
      4'h0:    rd = {a_q, b_q};
      4'h1:    rd = x_q;
      4'h2:    rd = y_q;
      4'h3:    rd = u_q;
      4'h4:    rd = s_q;
      4'h5:    rd = pc_q;
      4'h8:    rd = {{HW{1'b0}}, dp_q};
      4'h9:    rd = {{HW{1'b0}}, cc_q};
      4'hA:    rd = {{HW{1'b0}}, a_q};
      4'hB:    rd = {{HW{1'b0}}, b_q};
      default: rd = '0;
    endcase
  endfunction

  logic       accept, inv_now, width_bad;
  logic [3:0] pb_s, pb_d;

  assign pb_s   = postbyte[7:4];
  assign pb_d   = postbyte[3:0];
  assign accept = (state_q == StIdle) && start && (op == 8'h3E || op == 8'h3F);

`ifdef JTKCPU_XFR_MIXW_EN
  assign width_bad = 1'b0;
`else
  assign width_bad = is_word(pb_s) != is_word(pb_d);
`endif

  assign inv_now = !(is_word(pb_s) || is_byte(pb_s)) || !(is_word(pb_d) || is_byte(pb_d)) ||
                   width_bad;

  logic          wr_en;
  logic [3:0]    wr_sel;
  logic [DW-1:0] wr_data;

  // Single write port shared by the external loader (IDLE only) and the transfer sequence.
  always_comb begin
    wr_en   = 1'b0;
    wr_sel  = ld_sel;
    wr_data = ld_data;
    case (state_q)
      StIdle: wr_en = ld_en;
      StWrd: begin
        wr_en   = !inv_q;
        wr_sel  = dst_q;
        wr_data = fit(tmp_s_q, src_q, dst_q);
      end
      StWrs: begin
        wr_en   = !inv_q;
        wr_sel  = src_q;
        wr_data = fit(tmp_d_q, dst_q, src_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      dp_q    <= '0;
      cc_q    <= RST_CC;
      x_q     <= '0;
      y_q     <= '0;
      u_q     <= '0;
      s_q     <= '0;
      pc_q    <= RST_PC;
      tmp_s_q <= '0;
      tmp_d_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      exg_q   <= 1'b0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (cen) begin
      if (wr_en) begin
        case (wr_sel)
          4'h0:    {a_q, b_q} <= wr_data;
          4'h1:    x_q  <= wr_data;
          4'h2:    y_q  <= wr_data;
          4'h3:    u_q  <= wr_data;
          4'h4:    s_q  <= wr_data;
          4'h5:    pc_q <= wr_data;
          4'h8:    dp_q <= wr_data[HW-1:0];
          4'h9:    cc_q <= wr_data[HW-1:0];
          4'hA:    a_q  <= wr_data[HW-1:0];
          4'hB:    b_q  <= wr_data[HW-1:0];
          default: ;
        endcase
      end
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StRead;
            src_q   <= pb_s;
            dst_q   <= pb_d;
            exg_q   <= op == 8'h3E;
            inv_q   <= inv_now;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StRead: begin
          tmp_s_q <= rd(src_q);
          tmp_d_q <= rd(dst_q);
          state_q <= StWrd;
        end
        StWrd: begin
          if (exg_q) begin
            state_q <= StWrs;
          end else begin
            state_q <= StDone;
            done_q  <= 1'b1;
            err_q   <= inv_q;
          end
        end
        StWrs: begin
          state_q <= StDone;
          done_q  <= 1'b1;
          err_q   <= inv_q;
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign d    = {a_q, b_q};
  assign x    = x_q;
  assign y    = y_q;
  assign u    = u_q;
  assign s    = s_q;
  assign pc   = pc_q;
  assign dp   = dp_q;
  assign cc   = cc_q;
  assign a    = a_q;
  assign b    = b_q;

endmodule

// File: tb/tb_jtkcpu_regxfr.sv
// Bench for jtkcpu_regxfr: directed and random TFR/EXG against a transaction-level register model.
module tb_jtkcpu_regxfr;

  localparam logic [15:0] RstPc = 16'hC0DE;
  localparam logic [7:0]  RstCc = 8'h50;
`ifdef JTKCPU_XFR_MIXW_EN
  localparam bit Mixw = 1'b1;
`else
  localparam bit Mixw = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0, cen = 1'b0, start = 1'b0, ld_en = 1'b0;
  logic [7:0]  op = 8'h00, postbyte = 8'h00;
  logic [3:0]  ld_sel = 4'h0;
  logic [15:0] ld_data = 16'h0000;
  logic        busy, done, err;
  logic [15:0] d, x, y, u, s, pc;
  logic [7:0]  dp, cc, a, b;

  int tests = 0, fails = 0;

  logic [7:0]  ma, mb, mdp, mcc;
  logic [15:0] mx, my, mu, ms, mpc;
  bit          merr;

  jtkcpu_regxfr #(.DW(16), .RST_PC(RstPc), .RST_CC(RstCc)) dut (
    .rst(rst), .clk(clk), .cen(cen), .start(start), .op(op), .postbyte(postbyte),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data), .busy(busy), .done(done), .err(err),
    .d(d), .x(x), .y(y), .u(u), .s(s), .pc(pc), .dp(dp), .cc(cc), .a(a), .b(b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit mword(input int c);
    return c >= 0 && c <= 5;
  endfunction

  function automatic bit mvalid(input int c);
    return mword(c) || (c >= 8 && c <= 11);
  endfunction

  function automatic logic [15:0] mread(input int c);
    case (c)
      0: return {ma, mb};
      1: return mx;
      2: return my;
      3: return mu;
      4: return ms;
      5: return mpc;
      8: return {8'h00, mdp};
      9: return {8'h00, mcc};
      10: return {8'h00, ma};
      11: return {8'h00, mb};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic mwrite(input int c, input logic [15:0] v);
    case (c)
      0: {ma, mb} = v;
      1: mx = v;
      2: my = v;
      3: mu = v;
      4: ms = v;
      5: mpc = v;
      8: mdp = v[7:0];
      9: mcc = v[7:0];
      10: ma = v[7:0];
      11: mb = v[7:0];
      default: ;
    endcase
  endtask

  function automatic logic [15:0] adapt(input logic [15:0] v, input int from, input int to);
    if (mword(to) && !mword(from)) return {8'hFF, v[7:0]};
    return v;
  endfunction

  task automatic model_reset();
    ma = 0; mb = 0; mdp = 0; mcc = RstCc;
    mx = 0; my = 0; mu = 0; ms = 0; mpc = RstPc;
    merr = 0;
  endtask

  task automatic model_xfr(input logic [7:0] o, input logic [7:0] pb);
    int sc, dc;
    logic [15:0] vs, vd;
    bit bad;
    sc = int'(pb[7:4]);
    dc = int'(pb[3:0]);
    bad = !mvalid(sc) || !mvalid(dc) || (!Mixw && (mword(sc) != mword(dc)));
    merr = bad;
    if (!bad) begin
      vs = mread(sc);
      vd = mread(dc);
      mwrite(dc, adapt(vs, sc, dc));
      if (o == 8'h3E) mwrite(sc, adapt(vd, dc, sc));
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_d"}, d, {ma, mb});
    chk({tag, "_x"}, x, mx);
    chk({tag, "_y"}, y, my);
    chk({tag, "_u"}, u, mu);
    chk({tag, "_s"}, s, ms);
    chk({tag, "_pc"}, pc, mpc);
    chk({tag, "_dp"}, dp, mdp);
    chk({tag, "_cc"}, cc, mcc);
    chk({tag, "_a"}, a, ma);
    chk({tag, "_b"}, b, mb);
  endtask

  task automatic load(input logic [3:0] sel, input logic [15:0] v);
    cen = 1; ld_en = 1; ld_sel = sel; ld_data = v;
    tick();
    ld_en = 0;
    mwrite(int'(sel), v);
  endtask

  // extra: 1 = extra start while busy, 2 = load X while busy; tog = 50% cen toggling
  task automatic run_xfr(input string tag, input logic [7:0] o, input logic [7:0] pb,
                         input bit tog, input int extra);
    int n, k;
    op = o; postbyte = pb; start = 1; cen = 1;
    tick();
    start = 0; ld_en = 0;
    chk({tag, "_err_clr"}, err, 0);
    n = 1; k = 0;
    while (!done && n < 12 && k < 40) begin
      if (n == 1 && extra == 1) begin start = 1; op = 8'h3F; postbyte = 8'h45; end
      if (n == 1 && extra == 2) begin ld_en = 1; ld_sel = 4'h1; ld_data = 16'hDEAD; end
      if (tog) cen = ~cen;
      tick();
      if (cen) n++;
      k++;
      start = 0; ld_en = 0;
    end
    model_xfr(o, pb);
    chk({tag, "_latency"}, n, (o == 8'h3E) ? 4 : 3);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_err"}, err, merr);
    check_regs(tag);
    if (tog) begin
      cen = 0;
      tick();
      chk({tag, "_done_frozen"}, done, 1);
    end
    cen = 1;
    tick();
    chk({tag, "_done_low"}, done, 0);
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    logic [15:0] xprev;
    int vl[10] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11};
    int sc, dc;

    // Asynchronous reset, observed before any clock edge
    #2 rst = 1;
    #1;
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    check_regs("rst");
    tick();
    rst = 0;

    // X -> Y transfer
    load(4'h1, 16'h1234);
    run_xfr("tfr_xy", 8'h3F, 8'h12, 0, 0);
    chk("tfr_xy_const_y", y, 16'h1234);
    chk("tfr_xy_const_x", x, 16'h1234);

    // DP <-> CC exchange
    load(4'h8, 16'h0011);
    load(4'h9, 16'h0022);
    run_xfr("exg_dpcc", 8'h3E, 8'h89, 0, 0);
    chk("exg_dpcc_const_dp", dp, 8'h22);
    chk("exg_dpcc_const_cc", cc, 8'h11);
    chk("exg_dpcc_const_err", err, 0);

    // Byte A into word X
    load(4'hA, 16'h005A);
    xprev = x;
    run_xfr("tfr_ax", 8'h3F, 8'hA1, 0, 0);
    chk("tfr_ax_const_x", x, Mixw ? 16'hFF5A : xprev);

    // Invalid code: err sets and holds in IDLE; unknown op leaves it alone
    run_xfr("tfr_inv", 8'h3F, 8'h61, 0, 0);
    chk("inv_err_set", err, 1);
    tick();
    chk("inv_err_hold", err, 1);
    op = 8'h12; postbyte = 8'h12; start = 1;
    tick();
    start = 0;
    chk("badop_busy", busy, 0);
    chk("badop_err", err, 1);
    run_xfr("inv_clear", 8'h3F, 8'h21, 0, 0);
    chk("inv_clear_err", err, 0);

    // Same source and destination
    load(4'h1, 16'h0BEE);
    run_xfr("exg_same", 8'h3E, 8'h11, 0, 0);

    // Start and load while busy are both ignored
    load(4'h1, 16'h4444);
    run_xfr("busy_start", 8'h3F, 8'h12, 0, 1);
    run_xfr("busy_load", 8'h3F, 8'h13, 0, 2);
    chk("busy_load_x", x, 16'h4444);

    // Load and start on the same edge: READ sees the loaded value
    ld_en = 1; ld_sel = 4'h3; ld_data = 16'h7E57;
    mwrite(3, 16'h7E57);
    run_xfr("ld_start", 8'h3F, 8'h32, 0, 0);
    chk("ld_start_y", y, 16'h7E57);

    // U <-> S exchange with cen toggling
    load(4'h3, 16'hAAAA);
    load(4'h4, 16'h5555);
    run_xfr("exg_us_cen", 8'h3E, 8'h34, 1, 0);
    chk("exg_us_u", u, 16'h5555);
    chk("exg_us_s", s, 16'hAAAA);

    // Reset during WRD aborts the write
    load(4'h1, 16'h4321);
    load(4'h5, 16'h9999);
    op = 8'h3F; postbyte = 8'h12; start = 1;
    tick();
    start = 0;
    tick();
    rst = 1;
    #1;
    model_reset();
    chk("rstmid_y", y, 16'h0000);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_pc", pc, RstPc);
    chk("rstmid_done", done, 0);
    tick();
    rst = 0;
    check_regs("rstmid");
    load(4'h1, 16'h1357);
    run_xfr("post_rst", 8'h3F, 8'h12, 0, 0);

    // Random transfers
    for (int i = 0; i < 30; i++) begin
      load(4'($urandom_range(0, 15)), 16'($urandom));
      load(4'($urandom_range(0, 15)), 16'($urandom));
      sc = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : vl[$urandom_range(0, 9)];
      dc = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : vl[$urandom_range(0, 9)];
      run_xfr("rnd", ($urandom_range(0, 1) == 1) ? 8'h3E : 8'h3F, {4'(sc), 4'(dc)},
              bit'($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
